// File: rtl/sysbus_mem_target.sv
// Purpose: SysBus memory responder; decodes CtlBus loads/stores for DEV_ID against a 16-word store.
// Latency: load req at N drives data_oe in N+2 only; store data_in sampled at the edge ending N+1.
// Backpressure: none; a hit arriving while busy is dropped and flagged in sticky overrun.
module sysbus_mem_target #(
    parameter int         WORD_W   = 16,
    parameter logic [1:0] DEV_ID   = 2'd1,
    parameter bit         ROM_MODE = 1'b0
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req,
    input  logic [1:0]        dev,
    input  logic [3:0]        opaddr,
    input  logic              ldstr,
    input  logic [WORD_W-1:0] data_in,
    output logic [WORD_W-1:0] data_out,
    output logic              data_oe,
    output logic              busy,
    output logic              overrun,
    output logic              store_err
);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        RD_FETCH   = 2'd1,
        RD_DRIVE   = 2'd2,
        WR_CAPTURE = 2'd3
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [3:0]        addr_q;
    logic [WORD_W-1:0] rd_word;
    logic [WORD_W-1:0] mem [16];

    logic hit;
    logic accept;
    logic overrun_set;
    logic wr_en;
    logic wr_reject;

    assign hit = req && (dev == DEV_ID);

    always_comb begin
        state_nxt   = state;
        accept      = 1'b0;
        overrun_set = 1'b0;
        wr_en       = 1'b0;
        wr_reject   = 1'b0;
        data_oe     = 1'b0;
        busy        = 1'b0;
        data_out    = '0;
        unique case (state)
            IDLE: begin
                if (hit) begin
                    accept    = 1'b1;
                    state_nxt = ldstr ? RD_FETCH : WR_CAPTURE;
                end
            end
            RD_FETCH: begin
                busy        = 1'b1;
                overrun_set = hit;
                state_nxt   = RD_DRIVE;
            end
            RD_DRIVE: begin
                busy        = 1'b1;
                overrun_set = hit;
                data_oe     = 1'b1;
                data_out    = rd_word;
                state_nxt   = IDLE;
            end
            WR_CAPTURE: begin
                busy        = 1'b1;
                overrun_set = hit;
                wr_en       = !ROM_MODE;
                wr_reject   = ROM_MODE;
                state_nxt   = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Address is latched only on an accepted hit so mid-op CtlBus changes are ignored.
    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            addr_q    <= '0;
            rd_word   <= '0;
            overrun   <= 1'b0;
            store_err <= 1'b0;
            for (int i = 0; i < 16; i++) begin
                mem[i] <= '0;
            end
        end else begin
            state <= state_nxt;
            if (accept) begin
                addr_q <= opaddr;
            end
            if (state == RD_FETCH) begin
                rd_word <= mem[addr_q];
            end
            if (wr_en) begin
                mem[addr_q] <= data_in;
            end
            if (overrun_set) begin
                overrun <= 1'b1;
            end
            if (wr_reject) begin
                store_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_sysbus_mem_target.sv
// Directed bench for sysbus_mem_target: a RAM instance (dev 1) and a ROM instance (dev 2) share one CtlBus.
module tb_sysbus_mem_target;

    logic        clock = 1'b0;
    logic        reset;
    logic        req;
    logic [1:0]  dev;
    logic [3:0]  opaddr;
    logic        ldstr;
    logic [15:0] data_in;

    logic [15:0] ram_dout, rom_dout;
    logic        ram_oe, rom_oe, ram_busy, rom_busy;
    logic        ram_ovr, rom_ovr, ram_serr, rom_serr;

    int checks   = 0;
    int failures = 0;

    // cap_*[i] holds what was observed in cycle N+1+i of the last load
    logic [2:0]  cap_oe;
    logic [2:0]  cap_busy;
    logic [15:0] cap_dout [3];

    always #5 clock = ~clock;

    sysbus_mem_target #(.WORD_W(16), .DEV_ID(2'd1), .ROM_MODE(1'b0)) u_ram (
        .clock(clock), .reset(reset), .req(req), .dev(dev), .opaddr(opaddr),
        .ldstr(ldstr), .data_in(data_in), .data_out(ram_dout), .data_oe(ram_oe),
        .busy(ram_busy), .overrun(ram_ovr), .store_err(ram_serr)
    );

    sysbus_mem_target #(.WORD_W(16), .DEV_ID(2'd2), .ROM_MODE(1'b1)) u_rom (
        .clock(clock), .reset(reset), .req(req), .dev(dev), .opaddr(opaddr),
        .ldstr(ldstr), .data_in(data_in), .data_out(rom_dout), .data_oe(rom_oe),
        .busy(rom_busy), .overrun(rom_ovr), .store_err(rom_serr)
    );

    // All helpers are entered and left #1 after a rising edge.
    task automatic run_load(input logic rom, input logic [3:0] a);
        req    = 1'b1;
        dev    = rom ? 2'd2 : 2'd1;
        opaddr = a;
        ldstr  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clock); #1;
            req    = 1'b0;
            opaddr = ~a;
            ldstr  = 1'b0;
            cap_oe[i]   = rom ? rom_oe   : ram_oe;
            cap_busy[i] = rom ? rom_busy : ram_busy;
            cap_dout[i] = rom ? rom_dout : ram_dout;
        end
    endtask

    task automatic issue_store(input logic rom, input logic [3:0] a, input logic [15:0] v);
        req     = 1'b1;
        dev     = rom ? 2'd2 : 2'd1;
        opaddr  = a;
        ldstr   = 1'b0;
        data_in = 16'hDEAD;
        @(posedge clock); #1;
        req     = 1'b0;
        opaddr  = ~a;
        data_in = v;
        @(posedge clock); #1;
        data_in = 16'hF00D;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        checks++;
        if ({ram_oe, ram_busy, ram_ovr, ram_serr} !== 4'b0000) begin
            failures++;
            $display("FAIL reset_ram_flags got oe/busy/ovr/serr=%b want 0000", {ram_oe, ram_busy, ram_ovr, ram_serr});
        end
        checks++;
        if (ram_dout !== 16'h0000) begin
            failures++;
            $display("FAIL reset_ram_dout got %h want 0000", ram_dout);
        end
        checks++;
        if ({rom_oe, rom_busy, rom_ovr, rom_serr} !== 4'b0000 || rom_dout !== 16'h0000) begin
            failures++;
            $display("FAIL reset_rom got flags=%b dout=%h want 0000/0000", {rom_oe, rom_busy, rom_ovr, rom_serr}, rom_dout);
        end
    endtask

    task automatic test_load_all;
        for (int a = 0; a < 16; a++) begin
            run_load(1'b0, 4'(a));
            checks++;
            if (cap_oe !== 3'b010 || cap_busy !== 3'b011 || cap_dout[1] !== 16'h0000) begin
                failures++;
                $display("FAIL load_cleared addr=%0d got oe=%b busy=%b dout=%h want oe=010 busy=011 dout=0000",
                         a, cap_oe, cap_busy, cap_dout[1]);
            end
        end
    endtask

    task automatic test_store_load;
        issue_store(1'b0, 4'd5, 16'hBEEF);
        run_load(1'b0, 4'd5);
        checks++;
        if (cap_oe !== 3'b010 || cap_dout[1] !== 16'hBEEF) begin
            failures++;
            $display("FAIL store_load_5 got oe=%b dout=%h want oe=010 dout=beef", cap_oe, cap_dout[1]);
        end
        checks++;
        if (cap_dout[0] !== 16'h0000 || cap_dout[2] !== 16'h0000) begin
            failures++;
            $display("FAIL dout_idle_zero got n1=%h n3=%h want 0000/0000", cap_dout[0], cap_dout[2]);
        end
        run_load(1'b0, 4'd4);
        checks++;
        if (cap_oe !== 3'b010 || cap_dout[1] !== 16'h0000) begin
            failures++;
            $display("FAIL neighbour_addr4 got oe=%b dout=%h want oe=010 dout=0000", cap_oe, cap_dout[1]);
        end
        checks++;
        if (ram_serr !== 1'b0 || ram_ovr !== 1'b0) begin
            failures++;
            $display("FAIL ram_flags_after_store got serr=%b ovr=%b want 0/0", ram_serr, ram_ovr);
        end
    endtask

    task automatic test_dev_mismatch;
        logic seen;
        seen   = 1'b0;
        req    = 1'b1;
        dev    = 2'd3;
        opaddr = 4'd5;
        ldstr  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clock); #1;
            req  = 1'b0;
            seen = seen | ram_oe | rom_oe | ram_busy | rom_busy;
        end
        checks++;
        if (seen !== 1'b0) begin
            failures++;
            $display("FAIL dev_mismatch_activity got %b want 0", seen);
        end
        checks++;
        if ({ram_ovr, ram_serr, rom_ovr, rom_serr} !== 4'b0000) begin
            failures++;
            $display("FAIL dev_mismatch_flags got %b want 0000", {ram_ovr, ram_serr, rom_ovr, rom_serr});
        end
    endtask

    task automatic test_back_to_back;
        logic [15:0] first;
        issue_store(1'b0, 4'd6, 16'h1111);
        // load issued at N+2 of the store must already see the new word
        run_load(1'b0, 4'd6);
        first = cap_dout[1];
        checks++;
        if (cap_oe !== 3'b010 || first !== 16'h1111) begin
            failures++;
            $display("FAIL store_then_load_n2 got oe=%b dout=%h want oe=010 dout=1111", cap_oe, first);
        end
        run_load(1'b0, 4'd5);
        checks++;
        if (cap_oe !== 3'b010 || cap_busy !== 3'b011 || cap_dout[1] !== 16'hBEEF) begin
            failures++;
            $display("FAIL back_to_back_n3 got oe=%b busy=%b dout=%h want oe=010 busy=011 dout=beef",
                     cap_oe, cap_busy, cap_dout[1]);
        end
        checks++;
        if (ram_ovr !== 1'b0) begin
            failures++;
            $display("FAIL back_to_back_no_overrun got %b want 0", ram_ovr);
        end
    endtask

    task automatic test_overrun;
        int          pulses;
        logic [15:0] got;
        logic        oe_n2;
        issue_store(1'b0, 4'd3, 16'h0333);
        issue_store(1'b0, 4'd7, 16'h0777);
        pulses = 0;
        got    = 16'h0000;
        oe_n2  = 1'b0;
        req    = 1'b1;
        dev    = 2'd1;
        opaddr = 4'd3;
        ldstr  = 1'b1;
        @(posedge clock); #1;
        if (ram_oe) begin
            pulses++;
            got = ram_dout;
        end
        opaddr = 4'd7;
        for (int i = 0; i < 4; i++) begin
            @(posedge clock); #1;
            req = 1'b0;
            if (i == 0) oe_n2 = ram_oe;
            if (ram_oe) begin
                pulses++;
                got = ram_dout;
            end
        end
        checks++;
        if (ram_ovr !== 1'b1) begin
            failures++;
            $display("FAIL overrun_set got %b want 1", ram_ovr);
        end
        checks++;
        if (pulses != 1 || oe_n2 !== 1'b1) begin
            failures++;
            $display("FAIL overrun_single_pulse got pulses=%0d oe_n2=%b want 1/1", pulses, oe_n2);
        end
        checks++;
        if (got !== 16'h0333) begin
            failures++;
            $display("FAIL overrun_data got %h want 0333", got);
        end
        run_load(1'b0, 4'd7);
        checks++;
        if (ram_ovr !== 1'b1 || cap_dout[1] !== 16'h0777) begin
            failures++;
            $display("FAIL overrun_sticky got ovr=%b dout=%h want 1/0777", ram_ovr, cap_dout[1]);
        end
    endtask

    task automatic test_rom;
        issue_store(1'b1, 4'd2, 16'h1234);
        checks++;
        if (rom_serr !== 1'b1 || rom_busy !== 1'b0) begin
            failures++;
            $display("FAIL rom_store_err got serr=%b busy=%b want 1/0", rom_serr, rom_busy);
        end
        run_load(1'b1, 4'd2);
        checks++;
        if (cap_oe !== 3'b010 || cap_dout[1] !== 16'h0000) begin
            failures++;
            $display("FAIL rom_load_unchanged got oe=%b dout=%h want oe=010 dout=0000", cap_oe, cap_dout[1]);
        end
        checks++;
        if (ram_serr !== 1'b0) begin
            failures++;
            $display("FAIL ram_serr_untouched got %b want 0", ram_serr);
        end
    endtask

    task automatic test_reset_mid_op;
        issue_store(1'b0, 4'd9, 16'hAAAA);
        run_load(1'b0, 4'd9);
        checks++;
        if (cap_dout[1] !== 16'hAAAA) begin
            failures++;
            $display("FAIL pre_reset_store got %h want aaaa", cap_dout[1]);
        end
        req    = 1'b1;
        dev    = 2'd1;
        opaddr = 4'd9;
        ldstr  = 1'b0;
        @(posedge clock); #1;
        req     = 1'b0;
        data_in = 16'h5555;
        reset   = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        checks++;
        if ({ram_oe, ram_busy, ram_ovr, ram_serr, rom_serr} !== 5'b00000) begin
            failures++;
            $display("FAIL reset_mid_store got oe/busy/ovr/serr/romserr=%b want 00000",
                     {ram_oe, ram_busy, ram_ovr, ram_serr, rom_serr});
        end
        run_load(1'b0, 4'd9);
        checks++;
        if (cap_oe !== 3'b010 || cap_dout[1] !== 16'h0000) begin
            failures++;
            $display("FAIL reset_mid_store_mem got oe=%b dout=%h want oe=010 dout=0000", cap_oe, cap_dout[1]);
        end
        issue_store(1'b0, 4'd1, 16'h7777);
        req    = 1'b1;
        dev    = 2'd1;
        opaddr = 4'd1;
        ldstr  = 1'b1;
        @(posedge clock); #1;
        req   = 1'b0;
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        checks++;
        if (ram_oe !== 1'b0 || ram_dout !== 16'h0000 || ram_busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid_load got oe=%b dout=%h busy=%b want 0/0000/0", ram_oe, ram_dout, ram_busy);
        end
    endtask

    initial begin
        reset   = 1'b1;
        req     = 1'b0;
        dev     = 2'd0;
        opaddr  = 4'd0;
        ldstr   = 1'b0;
        data_in = 16'h0000;
        @(posedge clock); #1;
        test_reset();
        test_load_all();
        test_store_load();
        test_dev_mismatch();
        test_back_to_back();
        test_overrun();
        test_rom();
        test_reset_mid_op();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
